// File: rtl/obi_rr_neck_arbiter.sv
// Purpose: round-robin arbiter sharing one OBI slave port among NumMasters OBI masters.
// Latency: request/gnt path and rvalid/rdata routing are combinational (0 cycles); err_o one cycle after the stray rvalid.
// Backpressure: the selected master is locked until gnt; no request is forwarded while MaxOutstanding responses are pending.
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   master_req_i   per-master OBI request (req, we, be, addr, wdata)
//   master_resp_o  per-master gnt, rvalid, rdata
//   slave_req_o    request forwarded to the shared slave
//   slave_resp_i   shared slave gnt, rvalid, rdata
//   outstanding_o  granted transactions still awaiting rvalid
//   err_o          one-cycle pulse after an rvalid that arrived with nothing outstanding

package obi_rr_neck_pkg;
    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;
endpackage

module obi_rr_neck_arbiter
    import obi_rr_neck_pkg::*;
#(
    parameter int NumMasters     = 3,
    parameter int MaxOutstanding = 4,
    localparam int IdxWidth      = $clog2(NumMasters),
    localparam int CntWidth      = $clog2(MaxOutstanding + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  obi_req_t            master_req_i  [NumMasters],
    output obi_resp_t           master_resp_o [NumMasters],
    output obi_req_t            slave_req_o,
    input  obi_resp_t           slave_resp_i,
    output logic [CntWidth-1:0] outstanding_o,
    output logic                err_o
);

    localparam int PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

    logic [IdxWidth-1:0] rr_ptr;
    logic [IdxWidth-1:0] lock_idx;
    logic                lock_q;
    logic [IdxWidth-1:0] sel;
    logic                any_req;
    logic                full;
    logic                handshake;
    logic                pop;
    logic                err_q;

    // In-order record of which master owns each pending response.
    logic [IdxWidth-1:0] id_fifo [MaxOutstanding];
    logic [PtrWidth-1:0] wr_ptr;
    logic [PtrWidth-1:0] rd_ptr;
    logic [CntWidth-1:0] count;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(MaxOutstanding - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    assign full      = (count == CntWidth'(MaxOutstanding));
    assign handshake = slave_req_o.req & slave_resp_i.gnt;
    assign pop       = slave_resp_i.rvalid & (count != '0);

    // A locked master stays selected even if it drops req, so the slave
    // keeps seeing the same address/data until the handshake.
    always_comb begin
        int cand;
        cand    = 0;
        sel     = rr_ptr;
        any_req = 1'b0;
        if (lock_q) begin
            sel     = lock_idx;
            any_req = 1'b1;
        end else begin
            for (int k = 0; k < NumMasters; k++) begin
                cand = (int'(rr_ptr) + k) % NumMasters;
                if (!any_req && master_req_i[cand].req) begin
                    any_req = 1'b1;
                    sel     = IdxWidth'(cand);
                end
            end
        end
    end

    // Gating req with ~full (never with pop) keeps rvalid off the gnt path.
    always_comb begin
        slave_req_o = '0;
        if (any_req) begin
            slave_req_o     = master_req_i[sel];
            slave_req_o.req = master_req_i[sel].req & ~full;
        end
    end

    always_comb begin
        for (int i = 0; i < NumMasters; i++) begin
            master_resp_o[i]     = '0;
            master_resp_o[i].gnt = handshake & (sel == IdxWidth'(i));
            if (pop && (id_fifo[rd_ptr] == IdxWidth'(i))) begin
                master_resp_o[i].rvalid = 1'b1;
                master_resp_o[i].rdata  = slave_resp_i.rdata;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr   <= '0;
            lock_q   <= 1'b0;
            lock_idx <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= slave_resp_i.rvalid & (count == '0);

            if (handshake) begin
                lock_q <= 1'b0;
                rr_ptr <= (sel == IdxWidth'(NumMasters - 1)) ? '0 : sel + IdxWidth'(1);
            end else if (slave_req_o.req) begin
                lock_q   <= 1'b1;
                lock_idx <= sel;
            end

            if (handshake) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end

            case ({handshake, pop})
                2'b10:   count <= count + CntWidth'(1);
                2'b01:   count <= count - CntWidth'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry contents need no reset: they are only read while count != 0.
    always_ff @(posedge clk_i) begin
        if (handshake) begin
            id_fifo[wr_ptr] <= sel;
        end
    end

    assign outstanding_o = count;
    assign err_o         = err_q;

endmodule

// File: doc/obi_rr_neck_arbiter.md
Name: obi_rr_neck_arbiter

Overview:
Shares one OBI slave port (the neck in front of the 1-to-M system crossbar) among NumMasters OBI masters. Arbitration is round-robin and locks on the selected master until its request is granted. The block tracks outstanding transactions in an in-order ID FIFO so each rvalid/rdata is returned to the master that issued the request. It provides back-pressure when the outstanding limit is reached and flags responses that arrive when nothing is outstanding.

Parameters:
NumMasters, 3, number of OBI masters (>=2).
MaxOutstanding, 4, ID FIFO depth, i.e. the maximum number of granted requests still awaiting rvalid (>=1).
IdxWidth, localparam, $clog2(NumMasters).
CntWidth, localparam, $clog2(MaxOutstanding+1).

Ports:
clk_i  in  1  clock.
rst_i  in  1  reset; asynchronous, active-high.
master_req_i  in  obi_req_t [NumMasters]  master requests (req, we, be, addr, wdata).
master_resp_o  out  obi_resp_t [NumMasters]  per-master gnt, rvalid, rdata.
slave_req_o  out  obi_req_t  request to the shared slave.
slave_resp_i  in  obi_resp_t  shared slave response.
outstanding_o  out  CntWidth  number of granted transactions awaiting rvalid.
err_o  out  1  one-cycle pulse: rvalid received while outstanding_o==0.

Behaviour:
- Reset (rst_i high, asynchronous): rr pointer=0, lock=0, FIFO empty, outstanding_o=0, err_o=0. All master gnt/rvalid read 0 while slave_resp_i is idle. Outstanding responses are discarded.
- full = (outstanding_o==MaxOutstanding).
- Selection, unlocked: sel = first i with master_req_i[i].req, searching from the rr pointer upward with wrap-around modulo NumMasters.
- Selection, locked: sel = locked index.
- slave_req_o = master_req_i[sel], with slave_req_o.req = master_req_i[sel].req & ~full. All fields are 0 when no master requests.
- master_resp_o[i].gnt = slave_resp_i.gnt & slave_req_o.req & (sel==i). Request path is combinational, 0 cycles.
- Lock: if slave_req_o.req=1 and gnt=0, register lock=1 with locked index=sel. The address/data seen by the slave stay from the same master until gnt. Lock clears on the handshake.
- While full, the lock is held and no master is granted.
- Handshake (slave_req_o.req & slave_resp_i.gnt):
  - push sel into the FIFO;
  - rr pointer <= (sel+1) mod NumMasters;
  - lock <= 0.
- Response: when slave_resp_i.rvalid and FIFO not empty:
  - pop head h;
  - master_resp_o[h].rvalid=1 and rdata=slave_resp_i.rdata, combinational, same cycle;
  - all other masters get rvalid=0; rdata is don't-care (drive 0).
- Response with FIFO empty: no master rvalid, err_o=1 next cycle for one cycle, state unchanged.
- Simultaneous push and pop: count unchanged, FIFO order preserved.
- Push while full cannot happen because req is gated by ~full. A pop in the same cycle does not unblock the grant, so there is no rvalid->gnt combinational path.
- FIFO pointers wrap modulo MaxOutstanding.
- A master dropping req while it is locked (OBI violation): lock is held. slave_req_o.req follows that master's req (0), and the lock clears only on handshake.
- Masters may issue back-to-back requests. In-order responses from the slave are required.

Test Plan:
1. Masters 0,1,2 all hold req, slave gnt=1 every cycle, rvalid 2 cycles later -> grants in order 0,1,2,0,… one per cycle. Each master receives its own rdata (e.g. 0xA0+i); outstanding_o settles at 2.
2. Master 1 requests, gnt held 0 for 3 cycles while master 0 raises req in cycle 2 -> slave_req_o keeps master 1's addr all 3 cycles. Master 1 is granted first, then master 0.
3. MaxOutstanding=4, slave grants 4 requests from master 2 with no rvalid -> outstanding_o=4, fifth req not forwarded (slave_req_o.req=0). After 1 rvalid, the grant resumes in the following cycle.
4. Push and pop in the same cycle with outstanding_o=2 -> outstanding_o stays 2; responses are routed in issue order (1,0) with matching rdata.
5. rvalid injected with outstanding_o=0 -> no master rvalid, err_o pulses high for exactly one cycle.
6. Assert rst_i asynchronously with 3 outstanding -> outputs clear immediately and outstanding_o=0. After release, arbitration restarts at master 0.
